// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the program counter, drives the ROM fetch
// address, and captures the returned instruction into the fetch/decode register.
// Also handles start, halt, stall and branch redirect.
//
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   start_in            begin execution at START_ADDR (IDLE/HALTED only)
//   stall_in            hold PC, IR and state
//   branch_en_in        redirect fetch; squashes this cycle's fetch
//   branch_rel_in       1: target = ir_pc_out + sext(branch_offset_in); 0: branch_target_in
//   branch_target_in    absolute branch target
//   branch_offset_in    signed relative offset
//   instr_in            ROM data for pc_out (combinational)
//   pc_out              fetch address
//   ir_out, ir_pc_out   registered instruction and the address it came from
//   ir_valid_out        ir_out holds a valid, non-squashed instruction
//   done_out            high while halted
//   fetch_count_out     valid instructions delivered since last start (saturating)
module fetch_unit #(
    parameter logic [15:0] START_ADDR = 16'h0000,
    parameter logic [8:0]  HALT_OP    = 9'h1FF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_in,
    input  logic        stall_in,
    input  logic        branch_en_in,
    input  logic        branch_rel_in,
    input  logic [15:0] branch_target_in,
    input  logic [7:0]  branch_offset_in,
    input  logic [8:0]  instr_in,
    output logic [15:0] pc_out,
    output logic [8:0]  ir_out,
    output logic [15:0] ir_pc_out,
    output logic        ir_valid_out,
    output logic        done_out,
    output logic [15:0] fetch_count_out
);

    typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [8:0]  ir_q, ir_d;
    logic [15:0] ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic        done_q, done_d;
    logic [15:0] count_q, count_d;
    logic [15:0] branch_dest;

    // Relative branches are taken from the address of the instruction in the IR.
    assign branch_dest = branch_rel_in
                       ? ir_pc_q + {{8{branch_offset_in[7]}}, branch_offset_in}
                       : branch_target_in;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        count_d    = count_q;

        unique case (state_q)
            StIdle, StHalted: begin
                // The halt instruction is valid for exactly one cycle after entering HALTED.
                ir_valid_d = 1'b0;
                if (start_in) begin
                    state_d = StRun;
                    pc_d    = START_ADDR;
                    count_d = '0;
                end
            end
            StRun: begin
                if (branch_en_in) begin
                    // Branch wins over stall and squashes any halt fetched this cycle.
                    pc_d       = branch_dest;
                    ir_valid_d = 1'b0;
                end else if (!stall_in) begin
                    ir_d       = instr_in;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    if (instr_in == HALT_OP) begin
                        state_d = StHalted;
                    end else begin
                        pc_d = pc_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        done_d = (state_d == StHalted);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            pc_q       <= START_ADDR;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            done_q     <= done_d;
            count_q    <= count_d;
        end
    end

    assign pc_out          = pc_q;
    assign ir_out          = ir_q;
    assign ir_pc_out       = ir_pc_q;
    assign ir_valid_out    = ir_valid_q;
    assign done_out        = done_q;
    assign fetch_count_out = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_in, stall_in, branch_en_in, branch_rel_in;
    logic [15:0] branch_target_in;
    logic [7:0]  branch_offset_in;
    logic [8:0]  instr_in;
    logic [15:0] pc_out, ir_pc_out, fetch_count_out;
    logic [8:0]  ir_out;
    logic        ir_valid_out, done_out;

    logic [8:0]  rom [0:65535];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 = idle, 1 = running, 2 = halted
    int          m_mode;
    logic [15:0] m_pc, m_ir_pc, m_count;
    logic [8:0]  m_ir;
    logic        m_valid;

    always #5 clk = ~clk;

    assign instr_in = rom[pc_out];

    fetch_unit dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start_in         (start_in),
        .stall_in         (stall_in),
        .branch_en_in     (branch_en_in),
        .branch_rel_in    (branch_rel_in),
        .branch_target_in (branch_target_in),
        .branch_offset_in (branch_offset_in),
        .instr_in         (instr_in),
        .pc_out           (pc_out),
        .ir_out           (ir_out),
        .ir_pc_out        (ir_pc_out),
        .ir_valid_out     (ir_valid_out),
        .done_out         (done_out),
        .fetch_count_out  (fetch_count_out)
    );

    task automatic model_reset();
        m_mode = 0; m_pc = 16'h0000; m_ir = '0; m_ir_pc = '0; m_valid = 0; m_count = '0;
    endtask

    // One clock of the architectural rules, using the inputs currently applied.
    task automatic model_step();
        int tgt;
        if (m_mode != 1) begin
            m_valid = 0;
            if (start_in) begin
                m_mode = 1; m_pc = 16'h0000; m_count = 0;
            end
        end else if (branch_en_in) begin
            if (branch_rel_in) tgt = int'(m_ir_pc) + int'($signed(branch_offset_in));
            else               tgt = int'(branch_target_in);
            m_pc    = 16'(tgt);
            m_valid = 0;
        end else if (!stall_in) begin
            m_ir    = rom[m_pc];
            m_ir_pc = m_pc;
            m_valid = 1;
            if (m_count != 16'hFFFF) m_count = m_count + 1;
            if (m_ir == 9'h1FF) m_mode = 2;
            else                m_pc = m_pc + 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start_in = 0; stall_in = 0; branch_en_in = 0; branch_rel_in = 0;
        branch_target_in = '0; branch_offset_in = '0;
    endtask

    task automatic restart();
        @(negedge clk);
        reset_n = 0;
        model_reset();
        #1;
        reset_n = 1;
        start_in = 1;
        tick();
        start_in = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 0;
        model_reset();
        #3;
        n_tests++; if (pc_out !== 16'h0000) begin n_fail++;
            $display("FAIL reset_pc: got %h want 0000", pc_out); end
        n_tests++; if ({ir_out, ir_pc_out} !== 25'h0) begin n_fail++;
            $display("FAIL reset_ir: got %h/%h want 0/0", ir_out, ir_pc_out); end
        n_tests++; if ({ir_valid_out, done_out, fetch_count_out} !== 18'h0) begin n_fail++;
            $display("FAIL reset_flags: got %b %b %h want 0 0 0000",
                     ir_valid_out, done_out, fetch_count_out); end
        @(negedge clk);
        reset_n = 1;
        tick(); tick();
        n_tests++; if ({pc_out, ir_valid_out, done_out} !== 18'h0) begin n_fail++;
            $display("FAIL reset_idle: got pc=%h v=%b d=%b want idle", pc_out, ir_valid_out,
                     done_out); end
    endtask

    task automatic test_sequential();
        restart();
        n_tests++; if (pc_out !== 16'h0000 || ir_valid_out !== 1'b0) begin n_fail++;
            $display("FAIL start_state: got pc=%h v=%b want 0000 0", pc_out, ir_valid_out); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (ir_out !== 9'(i + 1) || ir_pc_out !== 16'(i) || ir_valid_out !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_fetch%0d: got ir=%h pc=%h v=%b want %h %h 1", i, ir_out,
                         ir_pc_out, ir_valid_out, 9'(i + 1), 16'(i));
            end
        end
        n_tests++; if (fetch_count_out !== 16'd3) begin n_fail++;
            $display("FAIL seq_count: got %0d want 3", fetch_count_out); end
    endtask

    task automatic test_stall();
        restart();
        tick(); tick();
        stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (pc_out !== 16'd2 || ir_out !== 9'h002 || fetch_count_out !== 16'd2) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got pc=%h ir=%h cnt=%0d want 0002 002 2", i,
                         pc_out, ir_out, fetch_count_out);
            end
        end
        stall_in = 0;
        tick();
        n_tests++;
        if (ir_out !== 9'h003 || ir_pc_out !== 16'd2 || fetch_count_out !== 16'd3) begin
            n_fail++;
            $display("FAIL stall_resume: got ir=%h pc=%h cnt=%0d want 003 0002 3", ir_out,
                     ir_pc_out, fetch_count_out);
        end
    endtask

    task automatic test_branch();
        restart();
        for (int i = 0; i < 17; i++) tick();
        n_tests++; if (ir_pc_out !== 16'h0010) begin n_fail++;
            $display("FAIL br_setup: got %h want 0010", ir_pc_out); end
        branch_en_in = 1; branch_rel_in = 1; branch_offset_in = 8'hFC;
        tick();
        branch_en_in = 0;
        n_tests++; if (ir_valid_out !== 1'b0 || pc_out !== 16'h000C) begin n_fail++;
            $display("FAIL br_rel_bubble: got v=%b pc=%h want 0 000c", ir_valid_out, pc_out); end
        tick();
        n_tests++; if (ir_pc_out !== 16'h000C || ir_valid_out !== 1'b1) begin n_fail++;
            $display("FAIL br_rel_target: got %h v=%b want 000c 1", ir_pc_out, ir_valid_out); end
        branch_en_in = 1; branch_rel_in = 0; branch_target_in = 16'hFFFF;
        tick();
        branch_en_in = 0;
        tick();
        n_tests++; if (ir_pc_out !== 16'hFFFF || pc_out !== 16'h0000) begin n_fail++;
            $display("FAIL br_abs_wrap: got irpc=%h pc=%h want ffff 0000", ir_pc_out, pc_out); end
        tick();
        n_tests++; if (ir_pc_out !== 16'h0000) begin n_fail++;
            $display("FAIL br_wrap_next: got %h want 0000", ir_pc_out); end
        branch_en_in = 1; stall_in = 1; branch_target_in = 16'h0123;
        tick();
        branch_en_in = 0; stall_in = 0;
        n_tests++; if (pc_out !== 16'h0123 || ir_valid_out !== 1'b0) begin n_fail++;
            $display("FAIL br_stall: got pc=%h v=%b want 0123 0", pc_out, ir_valid_out); end
        tick();
        n_tests++; if (ir_pc_out !== 16'h0123) begin n_fail++;
            $display("FAIL br_stall_target: got %h want 0123", ir_pc_out); end
    endtask

    task automatic test_halt();
        rom[5] = 9'h1FF;
        restart();
        for (int i = 0; i < 6; i++) tick();
        n_tests++;
        if (ir_out !== 9'h1FF || ir_valid_out !== 1'b1 || ir_pc_out !== 16'd5 ||
            done_out !== 1'b1 || pc_out !== 16'd5) begin
            n_fail++;
            $display("FAIL halt_enter: got ir=%h v=%b irpc=%h d=%b pc=%h want 1ff 1 5 1 5",
                     ir_out, ir_valid_out, ir_pc_out, done_out, pc_out);
        end
        branch_en_in = 1; branch_target_in = 16'h0040;
        tick();
        branch_en_in = 0;
        n_tests++;
        if (ir_valid_out !== 1'b0 || pc_out !== 16'd5 || done_out !== 1'b1 ||
            ir_out !== 9'h1FF || ir_pc_out !== 16'd5) begin
            n_fail++;
            $display("FAIL halt_hold: got v=%b pc=%h d=%b ir=%h irpc=%h want 0 5 1 1ff 5",
                     ir_valid_out, pc_out, done_out, ir_out, ir_pc_out);
        end
        start_in = 1;
        tick();
        start_in = 0;
        n_tests++;
        if (done_out !== 1'b0 || pc_out !== 16'h0000 || fetch_count_out !== 16'd0) begin
            n_fail++;
            $display("FAIL halt_restart: got d=%b pc=%h cnt=%0d want 0 0000 0", done_out,
                     pc_out, fetch_count_out);
        end
        tick();
        n_tests++;
        if (ir_pc_out !== 16'h0000 || ir_valid_out !== 1'b1 || fetch_count_out !== 16'd1) begin
            n_fail++;
            $display("FAIL halt_refetch: got irpc=%h v=%b cnt=%0d want 0000 1 1", ir_pc_out,
                     ir_valid_out, fetch_count_out);
        end
        rom[5] = 9'h005;
    endtask

    task automatic test_async_reset();
        restart();
        branch_en_in = 1; branch_target_in = 16'h0042;
        tick();
        branch_en_in = 0;
        tick();
        #2;
        reset_n = 0;
        model_reset();
        #1;
        n_tests++;
        if (pc_out !== 16'h0000 || ir_out !== 9'h0 || ir_pc_out !== 16'h0 ||
            ir_valid_out !== 1'b0 || done_out !== 1'b0 || fetch_count_out !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset: got pc=%h ir=%h irpc=%h v=%b d=%b cnt=%h want all 0",
                     pc_out, ir_out, ir_pc_out, ir_valid_out, done_out, fetch_count_out);
        end
        @(negedge clk);
        reset_n = 1;
        for (int i = 0; i < 3; i++) tick();
        n_tests++;
        if (pc_out !== 16'h0 || ir_valid_out !== 1'b0 || fetch_count_out !== 16'h0) begin
            n_fail++;
            $display("FAIL async_idle: got pc=%h v=%b cnt=%h want 0000 0 0000", pc_out,
                     ir_valid_out, fetch_count_out);
        end
    endtask

    task automatic test_saturation();
        logic [8:0]  saved;
        logic [15:0] hpc;
        restart();
        for (int i = 0; i < 65540; i++) begin
            tick();
            if (i == 65534) begin
                n_tests++; if (fetch_count_out !== 16'hFFFF) begin n_fail++;
                    $display("FAIL sat_reach: got %h want ffff", fetch_count_out); end
            end
        end
        n_tests++; if (fetch_count_out !== 16'hFFFF) begin n_fail++;
            $display("FAIL sat_stick: got %h want ffff", fetch_count_out); end
        hpc = pc_out;
        saved = rom[hpc];
        rom[hpc] = 9'h1FF;
        branch_en_in = 1; branch_rel_in = 0; branch_target_in = 16'h0100;
        tick();
        branch_en_in = 0;
        rom[hpc] = saved;
        n_tests++;
        if (done_out !== 1'b0 || ir_valid_out !== 1'b0 || pc_out !== 16'h0100) begin
            n_fail++;
            $display("FAIL squash_halt: got d=%b v=%b pc=%h want 0 0 0100", done_out,
                     ir_valid_out, pc_out);
        end
        tick();
        n_tests++; if (done_out !== 1'b0 || ir_valid_out !== 1'b1 || ir_pc_out !== 16'h0100)
        begin n_fail++;
            $display("FAIL squash_run: got d=%b v=%b irpc=%h want 0 1 0100", done_out,
                     ir_valid_out, ir_pc_out); end
    endtask

    task automatic test_random();
        logic [58:0] exp_v, got_v;
        for (int i = 0; i < 65536; i++)
            rom[i] = ($urandom_range(0, 39) == 0) ? 9'h1FF : 9'($urandom_range(0, 9'h1FE));
        restart();
        for (int c = 0; c < 3000; c++) begin
            start_in         = ($urandom_range(0, 19) == 0);
            stall_in         = ($urandom_range(0, 4) == 0);
            branch_en_in     = ($urandom_range(0, 9) == 0);
            branch_rel_in    = $urandom_range(0, 1);
            branch_target_in = 16'($urandom);
            branch_offset_in = 8'($urandom);
            tick();
            exp_v = {m_pc, m_ir, m_ir_pc, m_valid, (m_mode == 2), m_count};
            got_v = {pc_out, ir_out, ir_pc_out, ir_valid_out, done_out, fetch_count_out};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h want %h", c, got_v, exp_v);
            end
        end
        clear_inputs();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = {1'b0, 8'(i)};
        rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h003;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_halt();
        test_async_reset();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
